// File: rtl/dlx_inject_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlx_inject_pkg
// Description : Opcodes, NOP word and state encoding for DLX instruction
//               injection into the pipeline register file.
// Revision    : 1.0 - initial release
// ============================================================================
package dlx_inject_pkg;

    localparam logic [5:0]  OP_ADDI  = 6'b001000;
    localparam logic [5:0]  OP_ORI   = 6'b001101;
    localparam logic [5:0]  OP_LHI   = 6'b001111;

    // ADDI r0,r0,0
    localparam logic [31:0] NOP_WORD = {OP_ADDI, 5'd0, 5'd0, 16'd0};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EMIT_HI = 3'd1,
        ST_GAP_HI  = 3'd2,
        ST_EMIT_LO = 3'd3,
        ST_GAP_LO  = 3'd4,
        ST_DRAIN   = 3'd5
    } inject_state_t;

endpackage
`default_nettype wire

// File: rtl/dlx_itype_enc.sv
`default_nettype none
// ============================================================================
// Module      : dlx_itype_enc
// Description : Combinational DLX I-type word builder {op, rs1, rd, imm16}.
// Revision    : 1.0 - initial release
// ============================================================================
module dlx_itype_enc (
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word
);

    assign o_word = {i_op, i_rs1, i_rd, i_imm};

endmodule
`default_nettype wire

// File: rtl/reg_preload_injector.sv
`default_nettype none
// ============================================================================
// Module      : reg_preload_injector
// Description : Turns (register, value) entries into LHI/ORI instructions on
//               the core's instruction-override mux, padded with NOPs.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_preload_injector
    import dlx_inject_pkg::*;
#(
    parameter int NOP_GAP      = 4,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [4:0]  load_reg,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        override_inst,
    output logic [31:0] force_inst,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] c_gap_reload   = 4'(NOP_GAP - 1);
    localparam logic [3:0] c_drain_reload = 4'(DRAIN_CYCLES - 1);

    inject_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [4:0]    reg_q, reg_d;
    logic [31:0]   data_q, data_d;
    logic          last_q, last_d;
    logic          sess_q, sess_d;

    logic          load_ready_q, load_ready_d;
    logic          override_q, override_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   force_q, force_d;

    logic          w_accept;
    logic [5:0]    w_op;
    logic [4:0]    w_rs1;
    logic [15:0]   w_imm;
    logic [31:0]   w_word;

    assign w_accept = load_valid && load_ready_q && (state_q == ST_IDLE);

    dlx_itype_enc u_enc (
        .i_op   (w_op),
        .i_rs1  (w_rs1),
        .i_rd   (reg_q),
        .i_imm  (w_imm),
        .o_word (w_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        data_d  = data_q;
        last_d  = last_q;
        sess_d  = sess_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    reg_d  = load_reg;
                    data_d = load_data;
                    last_d = load_last;
                    sess_d = 1'b1;
                    if (load_reg == 5'd0) begin
                        // r0 is hardwired; only the session framing matters
                        if (load_last) begin
                            state_d = ST_DRAIN;
                            cnt_d   = c_drain_reload;
                        end
                    end else if (load_data[31:16] != 16'd0) begin
                        state_d = ST_EMIT_HI;
                    end else begin
                        state_d = ST_EMIT_LO;
                    end
                end
            end
            ST_EMIT_HI: begin
                state_d = ST_GAP_HI;
                cnt_d   = c_gap_reload;
            end
            ST_GAP_HI: begin
                if (cnt_q == 4'd0) state_d = ST_EMIT_LO;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_EMIT_LO: begin
                state_d = ST_GAP_LO;
                cnt_d   = c_gap_reload;
            end
            ST_GAP_LO: begin
                if (cnt_q == 4'd0) begin
                    if (last_q) begin
                        state_d = ST_DRAIN;
                        cnt_d   = c_drain_reload;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    sess_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sess_d  = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the current state, so each slot appears one
    // edge after the state that owns it.
    always_comb begin
        w_op  = OP_ORI;
        w_rs1 = (data_q[31:16] != 16'd0) ? reg_q : 5'd0;
        w_imm = data_q[15:0];
        if (state_q == ST_EMIT_HI) begin
            w_op  = OP_LHI;
            w_rs1 = 5'd0;
            w_imm = data_q[31:16];
        end

        force_d      = NOP_WORD;
        if ((state_q == ST_EMIT_HI) || (state_q == ST_EMIT_LO)) begin
            force_d = w_word;
        end
        load_ready_d = (state_q == ST_IDLE) && !w_accept;
        override_d   = sess_q;
        busy_d       = sess_q;
        done_d       = override_q && !sess_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            reg_q        <= 5'd0;
            data_q       <= 32'd0;
            last_q       <= 1'b0;
            sess_q       <= 1'b0;
            load_ready_q <= 1'b0;
            override_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            force_q      <= NOP_WORD;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
            last_q       <= last_d;
            sess_q       <= sess_d;
            load_ready_q <= load_ready_d;
            override_q   <= override_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            force_q      <= force_d;
        end
    end

    assign load_ready    = load_ready_q;
    assign override_inst = override_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign force_inst    = force_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_preload_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_preload_injector
// Description : Directed bench with a timeline model of the injector and a
//               small register-file executor fed by the override word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_preload_injector;

    localparam int          G   = 4;
    localparam int          D   = 5;
    localparam logic [31:0] NOP = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [4:0]  load_reg = 5'd0;
    logic [31:0] load_data = 32'd0;
    logic        load_last = 1'b0;
    logic        override_inst;
    logic [31:0] force_inst;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    reg_preload_injector #(.NOP_GAP(G), .DRAIN_CYCLES(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_reg      (load_reg),
        .load_data     (load_data),
        .load_last     (load_last),
        .override_inst (override_inst),
        .force_inst    (force_inst),
        .busy          (busy),
        .done          (done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Timeline model: each accepted entry expands into the list of words the
    // core must see, one per edge, followed by the drain and done slot.
    typedef struct {
        logic [31:0] f;
        bit          rdy;
        bit          ovr;
        bit          dn;
    } rec_t;

    rec_t        exp_q[$];
    int          cyc = 0;
    bit          m_ready = 0, m_ovr = 0, m_done = 0, m_sess = 0, m_acc = 0;
    logic [31:0] m_force = NOP;
    int          m_acc_cyc = 0;

    function automatic void push_rec(logic [31:0] f, bit rdy, bit ovr, bit dn);
        rec_t r;
        r.f = f; r.rdy = rdy; r.ovr = ovr; r.dn = dn;
        exp_q.push_back(r);
    endfunction

    function automatic void expand_entry(logic [4:0] rg, logic [31:0] dt, logic lst);
        logic [15:0] hi = dt[31:16];
        logic [15:0] lo = dt[15:0];
        if (rg != 5'd0) begin
            if (hi != 16'd0) begin
                push_rec({6'b001111, 5'd0, rg, hi}, 0, 1, 0);
                for (int k = 0; k < G; k++) push_rec(NOP, 0, 1, 0);
            end
            push_rec({6'b001101, (hi != 16'd0) ? rg : 5'd0, rg, lo}, 0, 1, 0);
            for (int k = 0; k < G; k++) push_rec(NOP, 0, 1, 0);
        end
        if (lst) begin
            for (int k = 0; k < D; k++) push_rec(NOP, 0, 1, 0);
            push_rec(NOP, 1, 0, 1);
        end
    endfunction

    always @(posedge clk) begin
        rec_t r;
        cyc++;
        m_acc = 0;
        if (reset) begin
            exp_q.delete();
            m_ready = 0; m_ovr = 0; m_done = 0; m_sess = 0; m_force = NOP;
        end else if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            m_force = r.f; m_ready = r.rdy; m_ovr = r.ovr; m_done = r.dn;
            if (r.dn) m_sess = 0;
        end else if (load_valid && m_ready) begin
            m_acc = 1; m_acc_cyc = cyc;
            m_ready = 0; m_ovr = m_sess; m_done = 0; m_force = NOP;
            m_sess = 1;
            expand_entry(load_reg, load_data, load_last);
        end else begin
            m_ready = 1; m_ovr = m_sess; m_done = 0; m_force = NOP;
        end
    end

    // Per-cycle compare plus logs for literal checks and a register-file
    // executor that retires whatever the override mux forwards.
    logic [31:0] flog [0:4095];
    logic        olog [0:4095];
    logic        dlog [0:4095];
    logic [31:0] rf   [0:31];

    initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;

    always @(negedge clk) begin
        vectors++;
        if ({load_ready, override_inst, busy, done, force_inst} !==
            {m_ready, m_ovr, m_ovr, m_done, m_force}) begin
            miscompares++;
            $display("FAIL cycle_%0d rdy/ovr/busy/done/force actual=%b%b%b%b %h expected=%b%b%b%b %h",
                     cyc, load_ready, override_inst, busy, done, force_inst,
                     m_ready, m_ovr, m_ovr, m_done, m_force);
        end
        if (cyc < 4096) begin
            flog[cyc] = force_inst;
            olog[cyc] = override_inst;
            dlog[cyc] = done;
        end
        if (override_inst === 1'b1) begin
            case (force_inst[31:26])
                6'b001111: rf[force_inst[20:16]] = {force_inst[15:0], 16'h0};
                6'b001101: rf[force_inst[20:16]] = rf[force_inst[25:21]] | {16'h0, force_inst[15:0]};
                default: ;
            endcase
            rf[0] = 32'd0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_accept(output int t);
        bit got = 0;
        t = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_acc) begin got = 1; t = m_acc_cyc; break; end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [4:0] rg, input logic [31:0] dt, input logic lst, output int t);
        @(negedge clk);
        load_valid = 1; load_reg = rg; load_data = dt; load_last = lst;
        wait_accept(t);
        load_valid = 0;
    endtask

    task automatic wait_end();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!m_sess && exp_q.size() == 0 && m_ready) begin ok = 1; break; end
        end
        if (!ok) check("session_end_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t, t1, t2, n;

        // Reset held with an entry presented: nothing may be accepted.
        load_valid = 1; load_reg = 5'd5; load_data = 32'h1111_2222; load_last = 1;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, load_ready}, 32'd0);
        check("reset_override", {31'd0, override_inst}, 32'd0);
        check("reset_force", force_inst, NOP);
        reset = 0; load_valid = 0;
        repeat (3) @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_ready", {31'd0, load_ready}, 32'd1);

        // Two-instruction entry, last of session.
        send(5'd5, 32'h1234_5678, 1, t);
        wait_end();
        check("r5_lhi", flog[t+1], 32'h3C05_1234);
        check("r5_gap", flog[t+2], NOP);
        check("r5_ori", flog[t+6], 32'h34A5_5678);
        check("r5_ovr_last", {31'd0, olog[t+15]}, 32'd1);
        check("r5_done", {31'd0, dlog[t+16]}, 32'd1);
        check("r5_ovr_fall", {31'd0, olog[t+16]}, 32'd0);
        check("r5_value", rf[5], 32'h1234_5678);

        // Upper half zero: single ORI from r0.
        send(5'd7, 32'h0000_00FF, 1, t);
        wait_end();
        check("r7_ori", flog[t+1], 32'h3407_00FF);
        check("r7_done", {31'd0, dlog[t+11]}, 32'd1);
        check("r7_value", rf[7], 32'h0000_00FF);

        // r0 entry: drain only.
        send(5'd0, 32'hDEAD_BEEF, 1, t);
        wait_end();
        n = 0;
        for (int k = 1; k <= 6; k++) if (flog[t+k] !== NOP) n++;
        check("r0_no_words", n, 0);
        check("r0_done", {31'd0, dlog[t+6]}, 32'd1);
        check("r0_value", rf[0], 32'd0);

        // Back-to-back with valid held high.
        @(negedge clk);
        load_valid = 1; load_reg = 5'd1; load_data = 32'hFFFF_0000; load_last = 0;
        wait_accept(t1);
        load_reg = 5'd2; load_data = 32'h0000_0001; load_last = 1;
        wait_accept(t2);
        load_valid = 0;
        wait_end();
        check("b2b_spacing", t2 - t1, 12);
        check("b2b_lhi", flog[t1+1], 32'h3C01_FFFF);
        check("b2b_ori1", flog[t1+6], 32'h3421_0000);
        check("b2b_ori2", flog[t2+1], 32'h3402_0001);
        n = 0;
        for (int k = t1 + 1; k <= t2 + 1; k++) if (olog[k] !== 1'b1) n++;
        check("b2b_override_held", n, 0);
        check("r1_value", rf[1], 32'hFFFF_0000);
        check("r2_value", rf[2], 32'h0000_0001);

        // Reset in the middle of GAP_HI, then a clean restart.
        send(5'd9, 32'hABCD_1234, 1, t);
        for (int k = 0; k < 50 && cyc < t + 3; k++) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("midrst_ready", {31'd0, load_ready}, 32'd0);
        check("midrst_override", {31'd0, override_inst}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_force", force_inst, NOP);
        check("r9_partial", rf[9], 32'hABCD_0000);
        reset = 0;
        send(5'd9, 32'hABCD_1234, 1, t);
        wait_end();
        check("r9_value", rf[9], 32'hABCD_1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
